// File: rtl/step_voice.sv
// rtl/step_voice.sv - percussive square-wave voice with linear amplitude decay
module step_voice #(
    parameter int CLK_Freq    = 50_000_000,
    parameter int SAMPLE_Freq = 16_000,
    parameter int AMP_MAX     = 24_000
) (
    input  logic        CLOCK_50,
    input  logic        iRST_N,
    input  logic        trigger,
    input  logic [15:0] tone_period,
    input  logic [14:0] decay_rate,
    output logic [15:0] audio_out_signed,
    output logic        sample_tick,
    output logic        busy
);

    localparam int                DIV       = CLK_Freq / SAMPLE_Freq;
    localparam int                DIV_W     = $clog2(DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [14:0]       AMP_START = 15'(AMP_MAX);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            r_state, w_state;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_tick;
    logic [14:0]       r_amp, w_amp;
    logic [15:0]       r_phase, w_phase;
    logic              r_pol, w_pol;
    logic [15:0]       r_per, w_per;
    logic [14:0]       r_dec, w_dec;
    logic [15:0]       r_audio, w_audio;
    logic              r_busy, w_busy;

    logic              w_tick_c;
    logic [15:0]       w_mag;
    logic [15:0]       w_sample;

    assign w_tick_c = (r_div_cnt == DIV_LAST);
    assign w_mag    = {1'b0, r_amp};
    assign w_sample = r_pol ? w_mag : -w_mag;

    assign audio_out_signed = r_audio;
    assign sample_tick      = r_tick;
    assign busy             = r_busy;

    // Free-running sample-rate divider; the tick pulse is registered so it lines up with the new sample
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= w_tick_c ? '0 : r_div_cnt + DIV_ONE;
            r_tick    <= w_tick_c;
        end
    end

    // Voice state and sample registers
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= IDLE;
            r_amp   <= '0;
            r_phase <= '0;
            r_pol   <= 1'b1;
            r_per   <= '0;
            r_dec   <= '0;
            r_audio <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_amp   <= w_amp;
            r_phase <= w_phase;
            r_pol   <= w_pol;
            r_per   <= w_per;
            r_dec   <= w_dec;
            r_audio <= w_audio;
            r_busy  <= w_busy;
        end
    end

    // Next-state: trigger restarts the voice and takes priority over a coincident sample tick
    always_comb begin
        w_state = r_state;
        w_amp   = r_amp;
        w_phase = r_phase;
        w_pol   = r_pol;
        w_per   = r_per;
        w_dec   = r_dec;
        w_audio = r_audio;
        w_busy  = r_busy;

        if (trigger) begin
            w_state = PLAY;
            w_amp   = AMP_START;
            w_phase = '0;
            w_pol   = 1'b1;
            w_per   = (tone_period == 16'd0) ? 16'd1 : tone_period;
            w_dec   = decay_rate;
            w_busy  = 1'b1;
            if (r_state == IDLE) begin
                w_audio = '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_audio = '0;
                    w_busy  = 1'b0;
                end
                PLAY: begin
                    if (w_tick_c) begin
                        if (r_amp == 15'd0) begin
                            w_audio = '0;
                            w_state = IDLE;
                            w_busy  = 1'b0;
                        end else begin
                            w_audio = w_sample;
                            w_amp   = (r_amp > r_dec) ? (r_amp - r_dec) : 15'd0;
                            if (r_phase == r_per - 16'd1) begin
                                w_phase = '0;
                                w_pol   = ~r_pol;
                            end else begin
                                w_phase = r_phase + 16'd1;
                            end
                        end
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_voice.sv
// tb/tb_step_voice.sv - scoreboard bench for step_voice
module tb_step_voice;

    logic        clk;
    logic        rst_n;
    logic        trigger;
    logic [15:0] tone_period;
    logic [14:0] decay_rate;
    logic [15:0] audio_out_signed;
    logic        sample_tick;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int exp_q[$];
    int busy_q[$];

    step_voice #(
        .CLK_Freq   (1600),
        .SAMPLE_Freq(100),
        .AMP_MAX    (1000)
    ) dut (
        .CLOCK_50        (clk),
        .iRST_N          (rst_n),
        .trigger         (trigger),
        .tone_period     (tone_period),
        .decay_rate      (decay_rate),
        .audio_out_signed(audio_out_signed),
        .sample_tick     (sample_tick),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sample_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push(input int s, input int b);
        exp_q.push_back(s);
        busy_q.push_back(b);
    endtask

    task automatic consume(input string tag);
        bit ok;
        int e;
        int eb;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            eb = busy_q.pop_front();
            wait_tick(ok);
            if (!ok) begin
                chk({tag, "_tick_timeout"}, 0, 1);
            end else begin
                chk({tag, "_sample"}, $signed(audio_out_signed), e);
                chk({tag, "_busy"}, {31'd0, busy}, eb);
            end
        end
    endtask

    // Trigger is sampled on the second posedge after the call; called just after a tick it avoids tick_c
    task automatic pulse_trigger();
        @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  s;

        rst_n       = 1'b0;
        trigger     = 1'b0;
        tone_period = 16'd2;
        decay_rate  = 15'd100;

        // reset with a trigger pulse that must be ignored
        repeat (2) @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_audio", $signed(audio_out_signed), 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_tick", {31'd0, sample_tick}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        wait_tick(ok);
        chk("rst_first_tick_seen", {31'd0, ok}, 1);
        chk("rst_idle_audio", $signed(audio_out_signed), 0);
        chk("rst_idle_busy", {31'd0, busy}, 0);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (sample_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tick_period", cyc, 16);

        // basic decay, with inputs changed after the trigger to prove they are latched
        tone_period = 16'd2;
        decay_rate  = 15'd100;
        pulse_trigger();
        tone_period = 16'd7;
        decay_rate  = 15'd3;
        chk("trig_busy", {31'd0, busy}, 1);
        chk("trig_audio_still0", $signed(audio_out_signed), 0);
        push(1000, 1); push(900, 1); push(-800, 1); push(-700, 1); push(600, 1);
        push(500, 1);  push(-400, 1); push(-300, 1); push(200, 1); push(100, 1);
        push(0, 0);    push(0, 0);   push(0, 0);
        consume("decay");

        // retrigger at sample 5
        tone_period = 16'd2;
        decay_rate  = 15'd100;
        pulse_trigger();
        push(1000, 1); push(900, 1); push(-800, 1); push(-700, 1); push(600, 1);
        consume("pre_retrig");
        pulse_trigger();
        push(1000, 1); push(900, 1); push(-800, 1);
        consume("retrig");

        // trigger coincident with tick_c: held sample, restart on following tick
        repeat (15) @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        @(negedge clk);
        chk("coll_tick", {31'd0, sample_tick}, 1);
        chk("coll_held", $signed(audio_out_signed), -800);
        push(1000, 1); push(900, 1);
        consume("coll_after");

        // large decay
        decay_rate = 15'd5000;
        pulse_trigger();
        push(1000, 1); push(0, 0); push(0, 0);
        consume("bigdec");

        // sustain with period 0
        tone_period = 16'd0;
        decay_rate  = 15'd0;
        pulse_trigger();
        for (int i = 0; i < 50; i++) begin
            s = (i % 2 == 0) ? 1000 : -1000;
            push(s, 1);
        end
        consume("sustain");

        // asynchronous reset mid-tone
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_audio", $signed(audio_out_signed), 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_tick", {31'd0, sample_tick}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        push(0, 0); push(0, 0); push(0, 0);
        consume("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
